// File: rtl/sprite_pkg.sv
// Shared sprite definitions: state codes (also decoded by the ROM renderer),
// the enum the sequencer uses, and sprite geometry.
package sprite_pkg;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_WALK        = 4'd1;
    localparam logic [3:0] ST_WALKBACK    = 4'd2;
    localparam logic [3:0] ST_ATTSTART    = 4'd3;
    localparam logic [3:0] ST_ATTEND      = 4'd4;
    localparam logic [3:0] ST_ATTPULL     = 4'd5;
    localparam logic [3:0] ST_DIRATTSTART = 4'd6;
    localparam logic [3:0] ST_DIRATTEND   = 4'd7;
    localparam logic [3:0] ST_DIRATTPULL  = 4'd8;
    localparam logic [3:0] ST_BLOCK       = 4'd9;
    localparam logic [3:0] ST_GOTHIT      = 4'd10;

    localparam logic [11:0] TRANSPARENT_COLOR = 12'hF0F;
    localparam int SPRITE_W = 150;
    localparam int SPRITE_H = 157;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_WALK     = ST_WALK,
        S_WALKBACK = ST_WALKBACK,
        S_ATTSTART = ST_ATTSTART,
        S_ATTEND   = ST_ATTEND,
        S_ATTPULL  = ST_ATTPULL,
        S_DIRSTART = ST_DIRATTSTART,
        S_DIREND   = ST_DIRATTEND,
        S_DIRPULL  = ST_DIRATTPULL,
        S_BLOCK    = ST_BLOCK,
        S_GOTHIT   = ST_GOTHIT
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return (s inside {S_ATTSTART, S_ATTEND, S_ATTPULL,
                          S_DIRSTART, S_DIREND, S_DIRPULL, S_GOTHIT});
    endfunction

    function automatic logic state_is_hitbox(input state_e s);
        return (s == S_ATTEND) || (s == S_DIREND);
    endfunction

endpackage

// File: rtl/sprite_state_seq_frame_hold_timer.sv
// Frame-count dwell timer: 5-bit loadable down-counter stepping on frame_tick,
// saturating at zero.
module frame_hold_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       dec_en,
    output logic       done
);

    logic [4:0] count_q;
    logic [4:0] count_d;

    always_comb begin
        count_d = count_q;
        if (frame_tick && load) begin
            count_d = load_val;
        end else if (frame_tick && dec_en && (count_q != 5'd0)) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 5'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 5'd0);

endmodule

// File: rtl/sprite_state_seq.sv
// Per-player animation sequencer: latches one-shot requests and steps the
// sprite state only on frame boundaries.
module sprite_state_seq
    import sprite_pkg::*;
#(
    parameter int unsigned HOLD_START = 6,
    parameter int unsigned HOLD_END   = 8,
    parameter int unsigned HOLD_PULL  = 4,
    parameter int unsigned HOLD_HIT   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       move_fwd,
    input  logic       move_back,
    input  logic       block_req,
    input  logic       attack_req,
    input  logic       dirattack_req,
    input  logic       hit_req,
    output logic [3:0] state,
    output logic       busy,
    output logic       hitbox_active,
    output logic       attack_ack
);

    localparam logic [4:0] LD_START = 5'(HOLD_START - 1);
    localparam logic [4:0] LD_END   = 5'(HOLD_END - 1);
    localparam logic [4:0] LD_PULL  = 5'(HOLD_PULL - 1);
    localparam logic [4:0] LD_HIT   = 5'(HOLD_HIT - 1);

    state_e     state_q, state_d;
    logic       p_att_q, p_att_d;
    logic       p_dir_q, p_dir_d;
    logic       p_hit_q, p_hit_d;
    logic       busy_q, hitbox_q, ack_q, ack_d;
    logic       eff_att, eff_dir, eff_hit;
    logic       tmr_load, tmr_dec, tmr_done;
    logic [4:0] tmr_val;

    frame_hold_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .dec_en     (tmr_dec),
        .done       (tmr_done)
    );

    // A request in the tick cycle itself must count, hence the OR with the input.
    assign eff_att = p_att_q | attack_req;
    assign eff_dir = p_dir_q | dirattack_req;
    assign eff_hit = p_hit_q | hit_req;

    always_comb begin
        state_d  = state_q;
        p_att_d  = eff_att;
        p_dir_d  = eff_dir;
        p_hit_d  = eff_hit;
        ack_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = 5'd0;
        if (frame_tick) begin
            // Every tick drains the request latches; busy-time attacks are dropped.
            p_att_d = 1'b0;
            p_dir_d = 1'b0;
            p_hit_d = 1'b0;
            if (eff_hit) begin
                state_d  = S_GOTHIT;
                tmr_load = 1'b1;
                tmr_val  = LD_HIT;
            end else if (!busy_q) begin
                if (eff_dir) begin
                    state_d  = S_DIRSTART;
                    tmr_load = 1'b1;
                    tmr_val  = LD_START;
                    ack_d    = 1'b1;
                end else if (eff_att) begin
                    state_d  = S_ATTSTART;
                    tmr_load = 1'b1;
                    tmr_val  = LD_START;
                    ack_d    = 1'b1;
                end else if (block_req) begin
                    state_d = S_BLOCK;
                end else if (move_fwd && !move_back) begin
                    state_d = S_WALK;
                end else if (move_back && !move_fwd) begin
                    state_d = S_WALKBACK;
                end else begin
                    state_d = S_IDLE;
                end
            end else if (!tmr_done) begin
                tmr_dec = 1'b1;
            end else begin
                unique case (state_q)
                    S_ATTSTART: begin state_d = S_ATTEND;  tmr_load = 1'b1; tmr_val = LD_END;  end
                    S_ATTEND:   begin state_d = S_ATTPULL; tmr_load = 1'b1; tmr_val = LD_PULL; end
                    S_DIRSTART: begin state_d = S_DIREND;  tmr_load = 1'b1; tmr_val = LD_END;  end
                    S_DIREND:   begin state_d = S_DIRPULL; tmr_load = 1'b1; tmr_val = LD_PULL; end
                    default:    state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            p_att_q  <= 1'b0;
            p_dir_q  <= 1'b0;
            p_hit_q  <= 1'b0;
            busy_q   <= 1'b0;
            hitbox_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_att_q  <= p_att_d;
            p_dir_q  <= p_dir_d;
            p_hit_q  <= p_hit_d;
            busy_q   <= state_is_busy(state_d);
            hitbox_q <= state_is_hitbox(state_d);
            ack_q    <= ack_d;
        end
    end

    assign state         = state_q;
    assign busy          = busy_q;
    assign hitbox_active = hitbox_q;
    assign attack_ack    = ack_q;

endmodule

// File: tb/tb_sprite_state_seq.sv
// Directed bench for sprite_state_seq with default hold lengths (6/8/4/12).
module tb_sprite_state_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_fwd = 1'b0;
    logic       move_back = 1'b0;
    logic       block_req = 1'b0;
    logic       attack_req = 1'b0;
    logic       dirattack_req = 1'b0;
    logic       hit_req = 1'b0;
    logic [3:0] state;
    logic       busy;
    logic       hitbox_active;
    logic       attack_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_state_seq dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .move_fwd      (move_fwd),
        .move_back     (move_back),
        .block_req     (block_req),
        .attack_req    (attack_req),
        .dirattack_req (dirattack_req),
        .hit_req       (hit_req),
        .state         (state),
        .busy          (busy),
        .hitbox_active (hitbox_active),
        .attack_ack    (attack_ack)
    );

    typedef struct {
        logic fwd;
        logic back;
        logic blk;
        int   st;
    } vec_t;

    vec_t vecs[8];

    function automatic int exp_busy(input int st);
        return ((st >= 3 && st <= 8) || st == 10) ? 1 : 0;
    endfunction

    function automatic int exp_hb(input int st);
        return (st == 4 || st == 7) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int ack);
        $display("t=%0t %s state=%0d busy=%0b hitbox=%0b ack=%0b",
                 $time, tag, state, busy, hitbox_active, attack_ack);
        chk({tag, " state"}, int'(state), st);
        chk({tag, " busy"}, int'(busy), exp_busy(st));
        chk({tag, " hitbox"}, int'(hitbox_active), exp_hb(st));
        chk({tag, " ack"}, int'(attack_ack), ack);
    endtask

    // Drives one frame_tick cycle with optional one-shot requests in that same cycle.
    task automatic tick_req(input logic a, input logic d, input logic h);
        @(negedge clk);
        frame_tick    = 1'b1;
        attack_req    = a;
        dirattack_req = d;
        hit_req       = h;
        @(negedge clk);
        frame_tick    = 1'b0;
        attack_req    = 1'b0;
        dirattack_req = 1'b0;
        hit_req       = 1'b0;
    endtask

    task automatic tick();
        tick_req(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input string tag, input int n, input int st);
        for (int i = 0; i < n; i++) begin
            tick();
            check_outs(tag, st, 0);
        end
    endtask

    task automatic pulse_att();
        @(negedge clk);
        attack_req = 1'b1;
        @(negedge clk);
        attack_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 9};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 9};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 2};

        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0);
        rst = 1'b1;

        // Level-driven, non-busy states
        for (int i = 0; i < 8; i++) begin
            move_fwd  = vecs[i].fwd;
            move_back = vecs[i].back;
            block_req = vecs[i].blk;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].st, 0);
        end
        move_fwd  = 1'b0;
        move_back = 1'b0;
        block_req = 1'b0;
        run("levels_off", 1, 0);

        // Full attack sequence from a request between ticks
        pulse_att();
        @(negedge clk);
        chk("att_wait_tick state", int'(state), 0);
        tick();
        check_outs("att_entry", 3, 1);
        @(negedge clk);
        chk("att_ack_width", int'(attack_ack), 0);
        run("att_start", 5, 3);
        run("att_end", 8, 4);
        run("att_pull", 4, 5);
        run("att_done", 2, 0);

        // Hit interrupts attend, hit during gothit reloads
        pulse_att();
        tick();
        check_outs("hit_att_entry", 3, 1);
        run("hit_att_start", 5, 3);
        run("hit_att_end", 3, 4);
        tick_req(1'b0, 1'b0, 1'b1);
        check_outs("hit_entry", 10, 0);
        run("gothit", 5, 10);
        tick_req(1'b0, 1'b0, 1'b1);
        check_outs("hit_reload", 10, 0);
        run("gothit2", 11, 10);
        run("hit_done", 1, 0);

        // Same-cycle arbitration: dirattack beats attack and walk
        move_fwd = 1'b1;
        tick_req(1'b1, 1'b1, 1'b0);
        check_outs("arb_entry", 6, 1);
        run("dir_start", 5, 6);
        run("dir_end", 8, 7);
        run("dir_pull", 4, 8);
        run("dir_done", 1, 0);
        run("dir_walk", 1, 1);
        move_fwd = 1'b0;
        run("dir_idle", 1, 0);

        // Attack requested while busy is dropped
        pulse_att();
        tick();
        check_outs("drop_entry", 3, 1);
        run("drop_start", 5, 3);
        run("drop_end", 8, 4);
        run("drop_pull1", 1, 5);
        pulse_att();
        tick();
        check_outs("drop_tick", 5, 0);
        run("drop_pull2", 2, 5);
        run("drop_done", 3, 0);

        // Asynchronous reset mid-attend with a request pending
        pulse_att();
        tick();
        check_outs("rst_att_entry", 3, 1);
        run("rst_att_start", 5, 3);
        run("rst_att_end", 5, 4);
        pulse_att();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("rst_async", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_outs("post_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
